// File: rtl/cpu_pkg.sv
// Shared CPU pipeline encodings: forwarding selects, EX stall codes and hazard FSM states.
package cpu_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [1:0] STALL_NONE   = 2'b00;
    localparam logic [1:0] STALL_HOLD   = 2'b01;
    localparam logic [1:0] STALL_BUBBLE = 2'b10;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_MEM_WAIT   = 2'd1,
        HZ_LOAD_STALL = 2'd2,
        HZ_FLUSH      = 2'd3
    } hz_state_e;

endpackage

// File: rtl/fwd_match.sv
// Single-source forwarding comparator: picks EX/MEM, MEM/WB or register file for one operand.
module fwd_match
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              use_rs,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_wr,
    output logic [1:0]        sel_c
);

    // x0 is never a forwarding source; the younger (EX) producer wins.
    always_comb begin
        sel_c = FWD_NONE;
        if (use_rs && ex_reg_wr && (ex_rd != '0) && (ex_rd == rs)) begin
            sel_c = FWD_EXMEM;
        end else if (use_rs && mem_reg_wr && (mem_rd != '0) && (mem_rd == rs)) begin
            sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard controller: registered EX forwarding selects and stall code, plus PC/pipe holds.
// Optional perf counters for load stalls, flushes and memory-wait cycles under HAZARD_PERF_EN.
module hazard_fwd_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned PERF_CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_reg,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_wr,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic [1:0]        fwd_rs1_out,
    output logic [1:0]        fwd_rs2_out,
    output logic [1:0]        ex_is_stall,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_hold,
    output logic              exmem_hold
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_load_stalls,
    output logic [PERF_CNT_W-1:0] perf_flushes,
    output logic [PERF_CNT_W-1:0] perf_mem_wait_cycles
`endif
);

    hz_state_e   state, state_nxt;
    logic [1:0]  fwd1_c, fwd2_c;
    logic [1:0]  fwd1_nxt, fwd2_nxt, stall_nxt;
    logic [1:0]  saved_stall, saved_nxt;
    logic        mw, lu, in_wait, take_br, take_lu;

    fwd_match #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .rs(id_rs1), .use_rs(id_use_rs1), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .sel_c(fwd1_c)
    );

    fwd_match #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .rs(id_rs2), .use_rs(id_use_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .sel_c(fwd2_c)
    );

    // An EX-stage match already implies ex_reg_wr and a non-zero destination.
    assign mw      = dmem_req && !dmem_ready;
    assign lu      = ex_mem_reg && ((fwd1_c == FWD_EXMEM) || (fwd2_c == FWD_EXMEM));
    assign in_wait = (state == HZ_MEM_WAIT);
    assign take_br = !mw && !in_wait && ex_branch_taken;
    assign take_lu = !mw && !in_wait && !ex_branch_taken && lu;

    always_comb begin
        state_nxt  = state;
        fwd1_nxt   = fwd_rs1_out;
        fwd2_nxt   = fwd_rs2_out;
        stall_nxt  = ex_is_stall;
        saved_nxt  = saved_stall;
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_hold  = 1'b0;
        exmem_hold = 1'b0;
        if (mw) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            if (!in_wait) saved_nxt = ex_is_stall;
            if (ex_is_stall == STALL_NONE) stall_nxt = STALL_HOLD;
            state_nxt = HZ_MEM_WAIT;
        end else if (in_wait) begin
            stall_nxt = saved_stall;
            state_nxt = HZ_RUN;
        end else if (take_br) begin
            ifid_flush = 1'b1;
            stall_nxt  = STALL_BUBBLE;
            fwd1_nxt   = FWD_NONE;
            fwd2_nxt   = FWD_NONE;
            state_nxt  = HZ_FLUSH;
        end else if (take_lu) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            stall_nxt = STALL_BUBBLE;
            fwd1_nxt  = FWD_NONE;
            fwd2_nxt  = FWD_NONE;
            state_nxt = HZ_LOAD_STALL;
        end else begin
            stall_nxt = STALL_NONE;
            fwd1_nxt  = fwd1_c;
            fwd2_nxt  = fwd2_c;
            state_nxt = HZ_RUN;
        end
        // Reset releases every hold in the same cycle it is seen.
        if (rst) begin
            pc_hold    = 1'b0;
            ifid_hold  = 1'b0;
            ifid_flush = 1'b0;
            idex_hold  = 1'b0;
            exmem_hold = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HZ_RUN;
            fwd_rs1_out <= FWD_NONE;
            fwd_rs2_out <= FWD_NONE;
            ex_is_stall <= STALL_BUBBLE;
            saved_stall <= STALL_NONE;
        end else begin
            state       <= state_nxt;
            fwd_rs1_out <= fwd1_nxt;
            fwd_rs2_out <= fwd2_nxt;
            ex_is_stall <= stall_nxt;
            saved_stall <= saved_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_stalls     <= '0;
            perf_flushes         <= '0;
            perf_mem_wait_cycles <= '0;
        end else begin
            if (take_lu && (perf_load_stalls != '1))
                perf_load_stalls <= perf_load_stalls + PERF_CNT_W'(1);
            if (take_br && (perf_flushes != '1))
                perf_flushes <= perf_flushes + PERF_CNT_W'(1);
            if (mw && (perf_mem_wait_cycles != '1))
                perf_mem_wait_cycles <= perf_mem_wait_cycles + PERF_CNT_W'(1);
        end
    end
`endif

endmodule
